// File: rtl/instr_decode_queue.sv
// instr_decode_queue: fetch-to-decode instruction FIFO.
// Holds up to DEPTH {pc, instruction} pairs. The head entry is shown with its
// MIPS fields split out and with coarse class flags for the controller.
// Optional macro INSTR_DECODE_QUEUE_EXT_IMM_EN adds the imm32 output, which is
// the extended immediate of the head entry.
module instr_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm16_or_offset,
  output logic [25:0]      PseudoAddr,
  output logic             bit16,
  output logic             is_rtype,
  output logic             is_branch,
  output logic             is_jump,
  output logic             is_mem,
`ifdef INSTR_DECODE_QUEUE_EXT_IMM_EN
  output logic [31:0]      imm32,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PC_W + 32;

  // Entry storage; deliberately not reset, valid data is tracked by count.
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Full/empty come from the occupancy count alone, so the pointers may wrap freely.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // A flush suppresses any transfer that would otherwise happen in the same cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Next-state for the pointers and the occupancy count; flush wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Store the accepted fetch entry at the write pointer.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_pc, in_instr};
  end

  // Head entry, zeroed when the queue is empty so every derived field reads 0.
  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;

  assign {head_pc, head_instr} = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_instr       = head_instr;
  assign out_pc          = head_pc;
  assign op              = head_instr[31:26];
  assign rs              = head_instr[25:21];
  assign rt              = head_instr[20:16];
  assign rd              = head_instr[15:11];
  assign shamt           = head_instr[10:6];
  assign funct           = head_instr[5:0];
  assign imm16_or_offset = head_instr[15:0];
  assign PseudoAddr      = head_instr[25:0];
  assign bit16           = head_instr[16];

  // Coarse classification of the head instruction; op==0 of a zeroed head must not flag R-type.
  always_comb begin
    is_rtype  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_mem    = 1'b0;
    if (out_valid) begin
      is_rtype  = (op == 6'h00);
      is_branch = (op == 6'h01) || (op == 6'h04) || (op == 6'h05) ||
                  (op == 6'h06) || (op == 6'h07);
      is_jump   = (op == 6'h02) || (op == 6'h03) ||
                  ((op == 6'h00) && ((funct == 6'h08) || (funct == 6'h09)));
      is_mem    = op[5];
    end
  end

`ifdef INSTR_DECODE_QUEUE_EXT_IMM_EN
  // Immediate extension: logical ops zero-extend, lui shifts up, the rest sign-extend.
  always_comb begin
    imm32 = '0;
    if (out_valid) begin
      case (op)
        6'h0C, 6'h0D, 6'h0E: imm32 = {16'h0000, imm16_or_offset};
        6'h0F:               imm32 = {imm16_or_offset, 16'h0000};
        default:             imm32 = {{16{imm16_or_offset[15]}}, imm16_or_offset};
      endcase
    end
  end
`endif

endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Parametrised instruction queue between fetch and decode.
- Buffers up to DEPTH fetched {pc, instruction} pairs and presents the head entry with all MIPS fields split out.
- Adds coarse class flags for the controller.
- Valid/ready handshake on both sides; synchronous flush for branch/jump redirect.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
PC_W, 32, program-counter width carried alongside each instruction
CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous queue clear, highest priority
in_valid  input  1  fetch presents an entry
in_ready  output  1  queue can accept (count < DEPTH)
in_instr  input  32  fetched instruction word
in_pc  input  PC_W  address of in_instr
out_valid  output  1  head entry valid (count != 0)
out_ready  input  1  decode consumes head this cycle
out_instr  output  32  head instruction word
out_pc  output  PC_W  head address
op  output  6  out_instr[31:26]
rs  output  5  out_instr[25:21]
rt  output  5  out_instr[20:16]
rd  output  5  out_instr[15:11]
shamt  output  5  out_instr[10:6]
funct  output  6  out_instr[5:0]
imm16_or_offset  output  16  out_instr[15:0]
PseudoAddr  output  26  out_instr[25:0]
bit16  output  1  out_instr[16] (REGIMM bltz/bgez select)
is_rtype  output  1  op == 6'h00
is_branch  output  1  op in {01,04,05,06,07}
is_jump  output  1  op in {02,03}, or R-type with funct in {08,09}
is_mem  output  1  op[5] == 1 (loads/stores)
count  output  CNT_W  current occupancy

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset state:
  - wr_ptr = rd_ptr = 0; count = 0; out_valid = 0.
  - in_ready = 1 once rst_n is high.
  - Storage array is not reset.
- Push:
  - Occurs when in_valid && in_ready && !flush.
  - Writes {in_pc, in_instr} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop:
  - Occurs when out_valid && out_ready && !flush.
  - rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
- in_ready:
  - Combinational: (count != DEPTH).
  - Does not depend on out_ready; no pass-through when full. A pop while full frees the slot next cycle.
- out_valid:
  - Combinational: (count != 0).
- Latency:
  - An entry pushed in cycle N is visible at the outputs in cycle N+1 (empty queue case).
  - No combinational path from in_* to out_*.
- Field decode:
  - All field and class outputs are decoded combinationally from the head entry.
  - When out_valid = 0, all field, class, out_instr and out_pc outputs are forced to 0.
- Empty with push and out_ready high:
  - No pop (out_valid = 0); entry appears next cycle.
- Full:
  - in_valid is ignored; the fetch side must hold in_instr/in_pc stable until accepted.
- Pointer wrap:
  - Pointers wrap silently; full/empty are derived from count only.
- Flush:
  - Next edge: count = 0, wr_ptr = rd_ptr = 0.
  - Any concurrent push or pop is discarded.
  - out_valid is 0 the cycle after flush; in_ready stays 1 during the flush cycle.
- Reset mid-operation:
  - Immediate return to reset state regardless of clk.
  - Entries are lost.

Optional Feature:
- Macro: INSTR_DECODE_QUEUE_EXT_IMM_EN.
- When defined:
  - Adds output imm32 [31:0].
  - Zero-extends imm16_or_offset for op in {0C andi, 0D ori, 0E xori}.
  - For op 0F lui, imm32 = {imm16, 16'h0}.
  - Sign-extends for all other ops.
  - Forced to 0 when out_valid = 0.
- When undefined:
  - Port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then push 32'h012A4020 (add $t0,$t1,$t2), pc 32'h00400000 → next cycle out_valid=1, op=0, rs=9, rt=10, rd=8, funct=6'h20, is_rtype=1, count=1.
- Push 4 entries with out_ready=0 (DEPTH=4) → count=4, in_ready=0; fifth in_valid held → not accepted; pop one → in_ready=1 next cycle, fifth accepted after.
- Continuous push and pop for 10 entries with incrementing pc → outputs in order, count stays 1, pointers wrap without loss.
- Push 32'h1109FFFE (beq) then 32'h0C100000 (jal) → is_branch=1 with imm16_or_offset=16'hFFFE, then is_jump=1 with PseudoAddr=26'h0100000.
- Queue holding 3 entries, flush with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, all field outputs 0, pushed entry discarded.
- EXT_IMM_EN defined: ori imm 16'h8000 → imm32=32'h00008000; addi imm 16'h8000 → 32'hFFFF8000; lui 16'h1234 → 32'h12340000.
